// File: rtl/pkt_stream_feeder.sv
// pkt_stream_feeder: streams one packet from the packet-buffer SRAM
// through a 2-entry prefetch FIFO with per-word ctrl/count side-band.
module pkt_stream_feeder #(
  parameter int DWIDTH     = 64,
  parameter int CTRL_WIDTH = DWIDTH/8,
  parameter int AWIDTH     = 10,
  parameter int HDR_WORDS  = 3
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  start,
  input  logic [AWIDTH-1:0]     base_addr,
  input  logic [15:0]           len_words,
  input  logic [3:0]            last_bytes,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_rd_en,
  output logic [AWIDTH-1:0]     ram_addr,
  input  logic [DWIDTH-1:0]     ram_rd_data,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [15:0]           data_count,
  output logic                  inside_payload
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0]     addr_q;
  logic [15:0]           rd_left_q;
  logic [15:0]           len_q;
  logic [15:0]           pop_idx_q;
  logic [CTRL_WIDTH-1:0] last_ctrl_q;
  logic [CTRL_WIDTH-1:0] last_ctrl_d;
  logic [CTRL_WIDTH-1:0] pop_ctrl;
  logic [3:0]            lb_norm;
  logic                  inflight_q;
  logic                  out_last_q;
  logic [DWIDTH-1:0]     fifo_mem [2];
  logic                  fifo_wp_q;
  logic                  fifo_rp_q;
  logic [1:0]            fifo_cnt_q;
  logic [2:0]            commit;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign accept = (state_q == IDLE) && start;
  assign push   = inflight_q;
  assign pop    = out_rdy && (fifo_cnt_q != 2'd0);

  // words still owed to the FIFO once this cycle's pop has left
  assign commit = {1'b0, fifo_cnt_q} + {2'b00, inflight_q}
                - {2'b00, pop};
  assign issue     = (state_q == RUN) && (commit < 3'd2);
  assign ram_rd_en = issue;
  assign ram_addr  = addr_q;

  always_comb begin
    lb_norm = last_bytes;
    if (last_bytes == 4'd0 || last_bytes > 4'd8) begin
      lb_norm = 4'd8;
    end
    last_ctrl_d = CTRL_WIDTH'(1) << (4'd8 - lb_norm);
  end

  always_comb begin
    pop_ctrl = '0;
    priority case (1'b1)
      (pop_idx_q == len_q - 16'd1): pop_ctrl = last_ctrl_q;
      (pop_idx_q == 16'd0):         pop_ctrl = CTRL_WIDTH'(8'hFF);
      default:                      pop_ctrl = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len_words == 16'd0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue && rd_left_q == 16'd1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_wr && out_last_q) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_q      <= '0;
      rd_left_q   <= '0;
      len_q       <= '0;
      last_ctrl_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d == RUN) || (state_d == DRAIN);
      done       <= (state_d == FIN);
      inflight_q <= issue;
      if (accept) begin
        addr_q      <= base_addr;
        rd_left_q   <= len_words;
        len_q       <= len_words;
        last_ctrl_q <= last_ctrl_d;
      end else if (issue) begin
        addr_q    <= addr_q + 1'b1;
        rd_left_q <= rd_left_q - 16'd1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_mem[fifo_wp_q] <= ram_rd_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fifo_wp_q      <= 1'b0;
      fifo_rp_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      out_wr         <= 1'b0;
      out_data       <= '0;
      out_ctrl       <= '0;
      data_count     <= '0;
      inside_payload <= 1'b0;
      out_last_q     <= 1'b0;
      pop_idx_q      <= '0;
    end else begin
      out_wr     <= pop;
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
        fifo_wp_q <= ~fifo_wp_q;
      end
      if (pop) begin
        fifo_rp_q      <= ~fifo_rp_q;
        out_data       <= fifo_mem[fifo_rp_q];
        out_ctrl       <= pop_ctrl;
        data_count     <= pop_idx_q;
        inside_payload <= (pop_idx_q >= 16'(HDR_WORDS));
        out_last_q     <= (pop_idx_q == len_q - 16'd1);
        pop_idx_q      <= pop_idx_q + 16'd1;
      end
      if (accept) begin
        pop_idx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pkt_stream_feeder.sv
// tb_pkt_stream_feeder: random packets against a queue-based model
// of the expected word stream, addresses and done timing.
module tb_pkt_stream_feeder;

  localparam int DW = 64;
  localparam int CW = DW/8;
  localparam int AW = 10;
  localparam int HW = 3;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
    logic [15:0]   cnt;
    logic          pl;
  } word_t;

  logic          i_clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   len_words = '0;
  logic [3:0]    last_bytes = '0;
  logic          busy;
  logic          done;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rd_data = '0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic [15:0]   data_count;
  logic          inside_payload;

  pkt_stream_feeder #(
    .DWIDTH(DW), .CTRL_WIDTH(CW), .AWIDTH(AW), .HDR_WORDS(HW)
  ) dut (
    .i_clock(i_clock),
    .i_reset_n(i_reset_n),
    .start(start),
    .base_addr(base_addr),
    .len_words(len_words),
    .last_bytes(last_bytes),
    .busy(busy),
    .done(done),
    .ram_rd_en(ram_rd_en),
    .ram_addr(ram_addr),
    .ram_rd_data(ram_rd_data),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .out_wr(out_wr),
    .out_rdy(out_rdy),
    .data_count(data_count),
    .inside_payload(inside_payload)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] sram [1<<AW];
  always @(posedge i_clock) begin
    if (ram_rd_en) ram_rd_data <= sram[ram_addr];
  end

  int cyc = 0;
  always @(posedge i_clock) cyc <= cyc + 1;

  // model state shared between the sequence and the monitor
  word_t         exp_q [$];
  word_t         mw;
  logic [AW-1:0] exp_addr = '0;
  int            reads_left = 0;
  int            reads_tot = 0;
  int            words_tot = 0;
  int            done_cnt = 0;
  int            done_cyc = -1;
  int            first_rd_cyc = -1;
  int            first_wr_cyc = -1;
  int            last_wr_cyc = -1;
  bit            rdy_prev = 1'b1;
  bit            hold_ok = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [CW-1:0] prev_ctrl = '0;
  logic [15:0]   prev_cnt = '0;
  int            rdy_mode = 0;
  int            pidx = 0;
  logic [5:0]    pat = 6'b101001;

  function automatic logic [CW-1:0] exp_ctrl(input int i, input int len,
                                             input int lb);
    int n;
    n = (lb < 1 || lb > 8) ? 8 : lb;
    if (i == len - 1) return CW'(2 ** (8 - n));
    if (i == 0) return CW'(8'hFF);
    return '0;
  endfunction

  always @(negedge i_clock) begin
    if (out_wr) begin
      check("wr_after_rdy0", rdy_prev, 1'b1);
      check("wr_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mw = exp_q.pop_front();
        check("data", out_data, mw.data);
        check("ctrl", out_ctrl, mw.ctrl);
        check("data_count", data_count, mw.cnt);
        check("inside_payload", inside_payload, mw.pl);
      end
      words_tot++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
    end else if (hold_ok) begin
      check("hold_data", out_data, prev_data);
      check("hold_ctrl", out_ctrl, prev_ctrl);
      check("hold_count", data_count, prev_cnt);
    end
    check("outstanding", (reads_tot - words_tot) <= 2, 1'b1);
    if (ram_rd_en) begin
      check("rd_expected", reads_left > 0, 1'b1);
      if (reads_left > 0) begin
        check("rd_addr", ram_addr, exp_addr);
        exp_addr = exp_addr + 1'b1;
        reads_left--;
      end
      reads_tot++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_at_done", busy, 1'b0);
    end
    prev_data = out_data;
    prev_ctrl = out_ctrl;
    prev_cnt  = data_count;
    rdy_prev  = out_rdy;
  end

  initial begin
    forever begin
      @(posedge i_clock);
      #1;
      if (rdy_mode == 0) out_rdy = 1'b1;
      else if (rdy_mode == 1) out_rdy = pat[pidx % 6];
      else out_rdy = 1'($urandom_range(0, 1));
      pidx++;
    end
  end

  task automatic load_pkt(input int base, input int len, input int lb);
    for (int i = 0; i < len; i++) begin
      word_t w;
      w.data = sram[(base + i) % (1 << AW)];
      w.ctrl = exp_ctrl(i, len, lb);
      w.cnt  = 16'(i);
      w.pl   = (i >= HW);
      exp_q.push_back(w);
    end
    exp_addr     = AW'(base);
    reads_left   = len;
    first_rd_cyc = -1;
    first_wr_cyc = -1;
    last_wr_cyc  = -1;
  endtask

  task automatic run_pkt(input int base, input int len, input int lb,
                         input int mode, input bit poke,
                         output int t0);
    int d0;
    load_pkt(base, len, lb);
    d0 = done_cnt;
    rdy_mode = mode;
    pidx = 0;
    @(posedge i_clock);
    #1;
    start      = 1'b1;
    base_addr  = AW'(base);
    len_words  = 16'(len);
    last_bytes = 4'(lb);
    @(posedge i_clock);
    #1;
    t0 = cyc;
    start = 1'b0;
    if (len > 0) check("busy_after_start", busy, 1'b1);
    if (poke) begin
      @(posedge i_clock);
      #1;
      start     = 1'b1;
      base_addr = AW'($urandom);
      len_words = 16'd9;
      @(posedge i_clock);
      #1;
      start = 1'b0;
    end
    for (int k = 0; k < 400 && done_cnt == d0; k++) begin
      @(negedge i_clock);
      #1;
    end
    repeat (3) @(posedge i_clock);
    #1;
    check("done_count", done_cnt - d0, 1);
    check("words_left", exp_q.size(), 0);
    check("reads_left", reads_left, 0);
    if (len > 0) check("done_latency", done_cyc - last_wr_cyc, 1);
    check("busy_end", busy, 1'b0);
    rdy_mode = 0;
  endtask

  int t0;
  int d0;
  int r0;
  int w0;

  initial begin
    for (int a = 0; a < (1 << AW); a++) sram[a] = {$urandom, $urandom};
    repeat (3) @(posedge i_clock);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", ram_rd_en, 1'b0);
    check("rst_addr", ram_addr, '0);
    check("rst_out_wr", out_wr, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_ctrl", out_ctrl, '0);
    check("rst_count", data_count, '0);
    check("rst_payload", inside_payload, 1'b0);
    #2 i_reset_n = 1'b1;
    @(negedge i_clock);
    #1 hold_ok = 1'b1;

    run_pkt(16'h010, 5, 8, 0, 1'b0, t0);
    check("first_rd_cycle", first_rd_cyc - t0, 0);
    check("first_wr_cycle", first_wr_cyc - t0, 3);
    check("wr_burst_len", last_wr_cyc - first_wr_cyc, 4);

    run_pkt(37, 1, 3, 0, 1'b0, t0);
    check("single_wr_cycle", first_wr_cyc - t0, 3);
    run_pkt(200, 6, 8, 1, 1'b0, t0);
    run_pkt(10'h3FE, 4, 8, 0, 1'b0, t0);
    run_pkt(500, 7, 5, 0, 1'b1, t0);

    // zero-length packet, start held into the FIN cycle
    d0 = done_cnt;
    r0 = reads_tot;
    w0 = words_tot;
    @(posedge i_clock);
    #1;
    start      = 1'b1;
    base_addr  = AW'(100);
    len_words  = 16'd0;
    last_bytes = 4'd8;
    @(posedge i_clock);
    #1;
    len_words = 16'd5;
    @(posedge i_clock);
    #1;
    start = 1'b0;
    repeat (12) @(posedge i_clock);
    #1;
    check("len0_done", done_cnt - d0, 1);
    check("len0_reads", reads_tot - r0, 0);
    check("len0_words", words_tot - w0, 0);
    check("len0_busy", busy, 1'b0);

    // reset after the second word of an 8-word packet
    load_pkt(300, 8, 8);
    d0 = done_cnt;
    w0 = words_tot;
    @(posedge i_clock);
    #1;
    start      = 1'b1;
    base_addr  = AW'(300);
    len_words  = 16'd8;
    last_bytes = 4'd8;
    @(posedge i_clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 50 && (words_tot - w0) < 2; k++) begin
      @(negedge i_clock);
      #1;
    end
    check("pre_reset_words", words_tot - w0, 2);
    hold_ok = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_done", done, 1'b0);
    check("ar_rd_en", ram_rd_en, 1'b0);
    check("ar_addr", ram_addr, '0);
    check("ar_out_wr", out_wr, 1'b0);
    check("ar_out_data", out_data, '0);
    check("ar_out_ctrl", out_ctrl, '0);
    check("ar_count", data_count, '0);
    check("ar_payload", inside_payload, 1'b0);
    exp_q.delete();
    reads_left = 0;
    reads_tot  = 0;
    words_tot  = 0;
    repeat (3) @(negedge i_clock);
    #2 i_reset_n = 1'b1;
    @(negedge i_clock);
    #1 hold_ok = 1'b1;
    repeat (10) @(posedge i_clock);
    #1;
    check("ar_no_done", done_cnt - d0, 0);
    run_pkt(700, 6, 2, 0, 1'b0, t0);

    for (int n = 0; n < 30; n++) begin
      int len;
      len = $urandom_range(1, 12);
      run_pkt($urandom_range(0, (1 << AW) - 1), len,
              $urandom_range(0, 15), $urandom_range(0, 2),
              (len >= 4) && ($urandom_range(0, 1) == 1), t0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
